// File: rtl/x_mem_responder.sv
// -----------------------------------------------------------------------------
// x_mem_responder
//
// Single-port memory/MMIO responder for a simple in-order core. A request is
// presented on i_valid and held until the one-cycle o_accept pulse completes
// it. Behind the port sit a word-addressed RAM, a GPIO output register and a
// free-running read-only cycle counter.
//
// Handshake: the core raises i_valid with i_rnw/i_addr/i_data stable. In the
// first IDLE cycle with i_valid=1 the request is captured; from then on the
// inputs are ignored. o_accept pulses high for exactly one cycle, 1+WAIT cycles
// after capture, with o_data/o_err valid in that same cycle. The core drops or
// replaces its request after seeing o_accept; the next request can be captured
// in the cycle right after the accept.
//
// Ports
//   i_clk      clock, all state on rising edge
//   i_rst      synchronous active-high reset
//   i_valid    request valid, held until accepted
//   i_rnw      1 = read, 0 = write
//   i_addr     byte address, bits [1:0] ignored
//   i_data     write data (full word)
//   o_accept   one-cycle completion pulse
//   o_data     read data, zero outside accept and for writes
//   o_gpio     GPIO register contents
//   o_err      one-cycle pulse with o_accept for an unmapped access
// -----------------------------------------------------------------------------
module x_mem_responder #(
  parameter int          DEPTH     = 1024,
  parameter int          WAIT      = 0,
  parameter logic [31:0] GPIO_ADDR = 32'h8000_0000,
  parameter logic [31:0] CNT_ADDR  = 32'h8000_0004
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_valid,
  input  logic        i_rnw,
  input  logic [31:0] i_addr,
  input  logic [31:0] i_data,
  output logic        o_accept,
  output logic [31:0] o_data,
  output logic [31:0] o_gpio,
  output logic        o_err
);

  localparam int          AW        = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [31:0] WAIT_INIT = (WAIT == 0) ? 32'd0 : 32'(WAIT - 1);

  typedef enum logic [1:0] {S_IDLE, S_HOLD, S_RESP} state_t;
  typedef enum logic [1:0] {SEL_RAM, SEL_GPIO, SEL_CNT, SEL_ERR} sel_t;

  state_t          r_state;
  sel_t            r_sel;
  logic            r_rnw;
  logic [AW-1:0]   r_idx;
  logic [31:0]     r_wdata;
  logic [31:0]     r_cnt;
  logic [31:0]     r_cnt_cap;
  logic [31:0]     r_wait;
  logic [31:0]     r_ram_q;
  logic [31:0]     r_gpio;
  logic            r_accept;
  logic [31:0]     r_mem [DEPTH];

  sel_t            w_sel;
  logic [29:0]     w_waddr;
  logic [AW-1:0]   w_idx;
  logic            w_capture;
  logic            w_ram_we;
  logic            w_unused;

  assign w_unused = ^i_addr[1:0];

  // Address decode on the incoming request. MMIO is checked first so an MMIO
  // address that happens to fall inside the RAM range still hits MMIO.
  always_comb begin
    w_waddr = i_addr[31:2];
    w_idx   = i_addr[AW+1:2];
    if (w_waddr == GPIO_ADDR[31:2])            w_sel = SEL_GPIO;
    else if (w_waddr == CNT_ADDR[31:2])        w_sel = SEL_CNT;
    else if ({2'b00, w_waddr} < 32'(DEPTH))    w_sel = SEL_RAM;
    else                                       w_sel = SEL_ERR;
  end

  assign w_capture = (r_state == S_IDLE) && i_valid && !i_rst;
  // Writes commit on the edge that ends the RESP cycle, unless reset wins.
  assign w_ram_we  = (r_state == S_RESP) && !r_rnw && (r_sel == SEL_RAM) && !i_rst;

  // RAM: synchronous read issued at capture, full-word write at commit.
  // Contents are deliberately not reset.
  always_ff @(posedge i_clk) begin
    if (w_capture) r_ram_q <= r_mem[w_idx];
    if (w_ram_we)  r_mem[r_idx] <= r_wdata;
  end

  // Request FSM, cycle counter and GPIO register.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state  <= S_IDLE;
      r_wait   <= '0;
      r_accept <= 1'b0;
      r_gpio   <= '0;
      r_cnt    <= '0;
    end else begin
      r_cnt    <= r_cnt + 32'd1;
      r_accept <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (i_valid) begin
            r_rnw     <= i_rnw;
            r_idx     <= w_idx;
            r_sel     <= w_sel;
            r_wdata   <= i_data;
            r_cnt_cap <= r_cnt;
            if (WAIT == 0) begin
              r_state  <= S_RESP;
              r_accept <= 1'b1;
            end else begin
              r_state <= S_HOLD;
              r_wait  <= WAIT_INIT;
            end
          end
        end
        S_HOLD: begin
          if (r_wait == 32'd0) begin
            r_state  <= S_RESP;
            r_accept <= 1'b1;
          end else begin
            r_wait <= r_wait - 32'd1;
          end
        end
        S_RESP: begin
          r_state <= S_IDLE;
          if (!r_rnw && (r_sel == SEL_GPIO)) r_gpio <= r_wdata;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Read data is only driven during the accept cycle of a read.
  always_comb begin
    o_data = '0;
    if (r_accept && r_rnw) begin
      case (r_sel)
        SEL_RAM:  o_data = r_ram_q;
        SEL_GPIO: o_data = r_gpio;
        SEL_CNT:  o_data = r_cnt_cap;
        default:  o_data = '0;
      endcase
    end
  end

  assign o_accept = r_accept;
  assign o_err    = r_accept && (r_sel == SEL_ERR);
  assign o_gpio   = r_gpio;

endmodule

// File: doc/x_mem_responder.md
X_MEM_RESPONDER -- requirements
Module: x_mem_responder

Interface
REQ-001 The block SHALL have parameter DEPTH, default 1024, meaning RAM size in 32-bit words (power of two).
REQ-002 The block SHALL have parameter WAIT, default 0, meaning extra wait cycles inserted before each accept.
REQ-003 The block SHALL have parameter GPIO_ADDR, default 32'h8000_0000, meaning the byte address of the GPIO output register.
REQ-004 The block SHALL have parameter CNT_ADDR, default 32'h8000_0004, meaning the byte address of the read-only cycle counter.
REQ-005 The block SHALL use one clock and a synchronous, active-high reset.
REQ-006 The block SHALL have port i_clk, input, 1, clock, all state on rising edge.
REQ-007 The block SHALL have port i_rst, input, 1, synchronous active-high reset.
REQ-008 The block SHALL have port i_valid, input, 1, request from core, held until accepted.
REQ-009 The block SHALL have port i_rnw, input, 1, 1 = read (fetch/load), 0 = write (store).
REQ-010 The block SHALL have port i_addr, input, 32, byte address; bits [1:0] ignored.
REQ-011 The block SHALL have port i_data, input, 32, write data, already masked by core for SB/SH.
REQ-012 The block SHALL have port o_accept, output, 1, one-cycle pulse completing the request.
REQ-013 The block SHALL have port o_data, output, 32, read data, valid during the o_accept cycle.
REQ-014 The block SHALL have port o_gpio, output, 32, GPIO register contents.
REQ-015 The block SHALL have port o_err, output, 1, one-cycle pulse with o_accept for an unmapped access.

Function
REQ-016 The FSM SHALL have states IDLE, HOLD and RESP.
REQ-017 In IDLE with i_valid=1, the block SHALL capture i_rnw, word address i_addr[31:2], i_data and the counter value, and SHALL issue the synchronous RAM read.
REQ-018 From that capture, the FSM SHALL go to RESP if WAIT==0, else to HOLD with wait counter loaded to WAIT-1.
REQ-019 In HOLD, the FSM SHALL decrement the wait counter and go to RESP in the cycle after it reads 0.
REQ-020 In RESP, the block SHALL assert o_accept=1 for exactly one cycle, then return to IDLE.
REQ-021 Latency SHALL be: o_accept asserted exactly 1+WAIT cycles after the first IDLE cycle with i_valid=1.
REQ-022 o_accept SHALL be 0 in IDLE and HOLD.
REQ-023 IDLE SHALL accept a new request in the cycle immediately after RESP, giving back-to-back throughput of one request per 2+WAIT cycles.
REQ-024 Reads SHALL decode as follows during the RESP cycle:
- RAM word when addr[31:2] < DEPTH;
- o_gpio when the address equals GPIO_ADDR;
- the captured counter when the address equals CNT_ADDR;
- otherwise 0 with o_err=1.
REQ-025 Writes SHALL commit on the RESP clock edge:
- RAM writes are full word, no byte lanes;
- GPIO_ADDR write updates o_gpio;
- CNT_ADDR write is ignored;
- an unmapped write is dropped with o_err=1.
REQ-026 o_data SHALL be 0 whenever o_accept=0, and 0 for write responses.
REQ-027 A read following a write to the same word SHALL return the written data.
REQ-028 The block SHALL use only captured request fields after IDLE, so changes on i_valid/i_addr/i_data mid-request do not affect the response and the request completes.
REQ-029 The cycle counter SHALL be free-running, increment every cycle and wrap 32'hFFFF_FFFF -> 0.
REQ-030 RAM SHALL be the lowest-priority decode, so an MMIO address inside RAM range hits MMIO.

Reset
REQ-031 i_rst=1 SHALL force state IDLE, wait counter 0, o_accept=0, o_err=0, o_data=0, o_gpio=0 and cycle counter 0 on the next edge.
REQ-032 Reset mid-request SHALL abandon the request with no accept and no write, and SHALL leave RAM contents unchanged.
REQ-033 After reset deassertion, the first cycle SHALL be IDLE and able to capture i_valid.

Verification
REQ-034 The bench SHALL cover: WAIT=0, write 32'hDEADBEEF to 0x10, then read 0x10 -> accept 1 cycle after each request; read o_data=32'hDEADBEEF.
REQ-035 The bench SHALL cover: WAIT=3, read 0x0 -> o_accept exactly 4 cycles after i_valid, single-cycle pulse, o_err=0.
REQ-036 The bench SHALL cover: write 32'h5A to GPIO_ADDR -> o_gpio=32'h5A from the cycle after accept; read GPIO_ADDR returns 32'h5A; write CNT_ADDR then read -> counter value, not write data.
REQ-037 The bench SHALL cover: read address DEPTH*4 -> o_data=0, o_err=1 with accept; write there, then read word 0 -> unchanged.
REQ-038 The bench SHALL cover: assert i_rst during HOLD of a write -> no accept, no RAM update, o_gpio=0; a following request completes normally.
REQ-039 The bench SHALL cover: back-to-back fetch, load, fetch with i_valid held high -> three accepts spaced 2+WAIT cycles apart, data matching RAM.
